// File: rtl/cic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cic_pkg : shared types and ratio helpers for the CIC decimation controller
// Revision : 1.0
// ---------------------------------------------------------------------------
package cic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMB = 2'd1,
        OUT  = 2'd2
    } cic_state_t;

    // Smallest ratio that leaves the shared comb sequence room to finish
    function automatic int unsigned MIN_RATIO(input int unsigned stages);
        return stages + 2;
    endfunction

    function automatic int unsigned clamp_ratio(input int unsigned ratio,
                                                input int unsigned stages);
        return (ratio < MIN_RATIO(stages)) ? MIN_RATIO(stages) : ratio;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_rate_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cic_rate_counter : period counter, ratio registers, wrap and decimated clock
// Revision : 1.0
// ---------------------------------------------------------------------------
module cic_rate_counter
    import cic_pkg::*;
#(
    parameter int STAGES    = 3,
    parameter int RATIO_W   = 6,
    parameter int DEF_RATIO = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [RATIO_W-1:0] ratio_cfg,
    input  logic               cfg_load,
    input  logic               idle,
    output logic               wrap,
    output logic               dwn_clk
);

    logic [RATIO_W-1:0] r_cnt;
    logic [RATIO_W-1:0] r_ratio_pend;
    logic [RATIO_W-1:0] r_ratio_q;
    logic               r_dwn_clk;
    logic [RATIO_W-1:0] w_ratio_clamped;
    logic [RATIO_W-1:0] w_hi_last;

    assign w_ratio_clamped = RATIO_W'(clamp_ratio(32'(ratio_cfg), STAGES));
    assign wrap            = enable && (r_cnt == (r_ratio_q - RATIO_W'(1)));
    // ratio_q only moves at a wrap or while stopped, so it still holds the
    // value captured at the wrap that raised dwn_clk
    assign w_hi_last       = (r_ratio_q >> 1) - RATIO_W'(1);
    assign dwn_clk         = r_dwn_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_ratio_pend <= RATIO_W'(DEF_RATIO);
            r_ratio_q    <= RATIO_W'(DEF_RATIO);
            r_dwn_clk    <= 1'b0;
        end else begin
            if (cfg_load) begin
                r_ratio_pend <= w_ratio_clamped;
            end
            if (wrap || (!enable && idle)) begin
                r_ratio_q <= r_ratio_pend;
            end
            if (!enable) begin
                r_cnt     <= '0;
                r_dwn_clk <= 1'b0;
            end else if (wrap) begin
                r_cnt     <= '0;
                r_dwn_clk <= 1'b1;
            end else begin
                r_cnt <= r_cnt + RATIO_W'(1);
                if (r_cnt == w_hi_last) begin
                    r_dwn_clk <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cic_decim_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cic_decim_ctrl : decimation strobe and shared comb-stage sequencer
// Revision : 1.0
// ---------------------------------------------------------------------------
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int STAGES    = 3,
    parameter int RATIO_W   = 6,
    parameter int DEF_RATIO = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [RATIO_W-1:0]         ratio_cfg,
    input  logic                       cfg_load,
    output logic                       sample_stb,
    output logic                       comb_en,
    output logic [$clog2(STAGES)-1:0]  comb_sel,
    output logic                       out_load,
    output logic                       dwn_clk
);

    localparam int                c_sel_w      = $clog2(STAGES);
    localparam logic [c_sel_w-1:0] c_last_stage = c_sel_w'(STAGES - 1);

    cic_state_t         r_state;
    cic_state_t         w_state_nxt;
    logic [c_sel_w-1:0] r_stage;
    logic [c_sel_w-1:0] w_stage_nxt;
    logic               w_wrap;
    logic               w_idle;
    logic               w_stb_nxt;
    logic               w_comb_en_nxt;
    logic [c_sel_w-1:0] w_comb_sel_nxt;
    logic               w_out_load_nxt;

    assign w_idle = (r_state == IDLE);

    cic_rate_counter #(
        .STAGES    (STAGES),
        .RATIO_W   (RATIO_W),
        .DEF_RATIO (DEF_RATIO)
    ) u_rate (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .ratio_cfg (ratio_cfg),
        .cfg_load  (cfg_load),
        .idle      (w_idle),
        .wrap      (w_wrap),
        .dwn_clk   (dwn_clk)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        case (r_state)
            IDLE: begin
                if (w_wrap) begin
                    w_state_nxt = COMB;
                    w_stage_nxt = '0;
                end
            end
            COMB: begin
                if (r_stage == c_last_stage) begin
                    w_state_nxt = OUT;
                    w_stage_nxt = '0;
                end else begin
                    w_stage_nxt = r_stage + c_sel_w'(1);
                end
            end
            OUT:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it
        w_stb_nxt      = w_idle && w_wrap;
        w_comb_en_nxt  = (w_state_nxt == COMB);
        w_comb_sel_nxt = (w_state_nxt == COMB) ? w_stage_nxt : '0;
        w_out_load_nxt = (w_state_nxt == OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_stage    <= '0;
            sample_stb <= 1'b0;
            comb_en    <= 1'b0;
            comb_sel   <= '0;
            out_load   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_stage    <= w_stage_nxt;
            sample_stb <= w_stb_nxt;
            comb_en    <= w_comb_en_nxt;
            comb_sel   <= w_comb_sel_nxt;
            out_load   <= w_out_load_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cic_decim_ctrl : self-checking bench for cic_decim_ctrl
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_cic_decim_ctrl;

    localparam int STAGES    = 3;
    localparam int RATIO_W   = 6;
    localparam int DEF_RATIO = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic [RATIO_W-1:0] ratio_cfg = '0;
    logic               cfg_load = 1'b0;
    logic               sample_stb;
    logic               comb_en;
    logic [1:0]         comb_sel;
    logic               out_load;
    logic               dwn_clk;

    int n_checks = 0;
    int n_errors = 0;

    cic_decim_ctrl #(
        .STAGES    (STAGES),
        .RATIO_W   (RATIO_W),
        .DEF_RATIO (DEF_RATIO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .ratio_cfg  (ratio_cfg),
        .cfg_load   (cfg_load),
        .sample_stb (sample_stb),
        .comb_en    (comb_en),
        .comb_sel   (comb_sel),
        .out_load   (out_load),
        .dwn_clk    (dwn_clk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Model: position within the period, age since the last strobe, and
    // the high length of dwn_clk for the current period.
    int m_pos, m_ratio, m_pend, m_age, m_hi, m_nr;
    bit m_dwn_on, m_wrap;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos = 0; m_ratio = DEF_RATIO; m_pend = DEF_RATIO;
            m_age = -1; m_hi = 0; m_dwn_on = 1'b0;
        end else begin
            m_wrap = enable && (m_pos == m_ratio - 1);
            m_nr   = m_ratio;
            if (m_wrap || (!enable && m_age < 0)) m_nr = m_pend;
            if (cfg_load) m_pend = (int'(ratio_cfg) < STAGES + 2) ? STAGES + 2 : int'(ratio_cfg);
            m_ratio = m_nr;
            if (m_wrap) begin
                m_age = 0; m_dwn_on = 1'b1; m_hi = m_nr / 2;
            end else if (m_age >= 0) begin
                m_age = (m_age == STAGES) ? -1 : m_age + 1;
            end
            if (!enable) m_dwn_on = 1'b0;
            m_pos = (enable && !m_wrap) ? m_pos + 1 : 0;
        end
    end

    always @(negedge clk) begin
        chk("stb",      int'(sample_stb), int'(m_age == 0));
        chk("comb_en",  int'(comb_en),    int'(m_age >= 0 && m_age < STAGES));
        chk("comb_sel", int'(comb_sel),   (m_age >= 0 && m_age < STAGES) ? m_age : 0);
        chk("out_load", int'(out_load),   int'(m_age == STAGES));
        chk("dwn_clk",  int'(dwn_clk),    int'(m_dwn_on && m_pos < m_hi));
    end

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_cfg(input int val);
        ratio_cfg = RATIO_W'(val);
        cfg_load  = 1'b1;
        @(negedge clk);
        cfg_load  = 1'b0;
    endtask

    // Cycles to the next strobe, dwn_clk high count and first out_load index
    task automatic wait_stb(output int n, output int hi, output int ol);
        n = 0; hi = 0; ol = -1;
        do begin
            @(negedge clk);
            n++;
            if (dwn_clk) hi++;
            if (out_load && ol < 0) ol = n;
        end while (!sample_stb && n < 200);
        if (!sample_stb) chk("stb_timeout", n, -1);
    endtask

    int n, hi, ol, nstb;

    initial begin
        skip(3);
        chk("rst_stb", int'(sample_stb), 0);
        chk("rst_dwn", int'(dwn_clk), 0);
        rst = 1'b0;
        enable = 1'b1;

        wait_stb(n, hi, ol);
        chk("first_stb", n, 32);
        wait_stb(n, hi, ol);
        chk("period_def", n, 32);
        chk("dwn_hi_def", hi, 16);
        chk("outload_pos", ol, 3);

        skip(5);
        pulse_cfg(8);
        wait_stb(n, hi, ol);
        chk("period_hold", n + 6, 32);
        wait_stb(n, hi, ol);
        chk("period_8", n, 8);
        chk("dwn_hi_8", hi, 4);
        chk("outload_pos_8", ol, 3);

        skip(7);
        pulse_cfg(16);
        chk("stb_at_cfg_wrap", int'(sample_stb), 1);
        wait_stb(n, hi, ol);
        chk("period_delayed", n, 8);
        wait_stb(n, hi, ol);
        chk("period_16", n, 16);
        chk("dwn_hi_16", hi, 8);

        skip(3);
        pulse_cfg(2);
        wait_stb(n, hi, ol);
        chk("period_hold16", n + 4, 16);
        wait_stb(n, hi, ol);
        chk("clamp2_period", n, 5);
        chk("clamp2_hi", hi, 2);
        chk("clamp2_outload", ol, 3);

        pulse_cfg(0);
        wait_stb(n, hi, ol);
        chk("clamp0_hold", n + 1, 5);
        wait_stb(n, hi, ol);
        chk("clamp0_period", n, 5);
        chk("clamp0_hi", hi, 2);

        enable = 1'b0;
        nstb = 0; ol = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (sample_stb) nstb++;
            if (out_load && ol < 0) ol = i;
        end
        chk("dis_outload_pos", ol, 3);
        chk("dis_no_stb", nstb, 0);
        chk("dis_dwn", int'(dwn_clk), 0);
        pulse_cfg(8);
        skip(1);
        enable = 1'b1;
        wait_stb(n, hi, ol);
        chk("reenable_first", n, 8);
        wait_stb(n, hi, ol);
        chk("reenable_period", n, 8);

        @(negedge clk);
        chk("pre_rst_comb_en", int'(comb_en), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_stb",      int'(sample_stb), 0);
        chk("arst_comb_en",  int'(comb_en), 0);
        chk("arst_comb_sel", int'(comb_sel), 0);
        chk("arst_out_load", int'(out_load), 0);
        chk("arst_dwn",      int'(dwn_clk), 0);
        skip(2);
        rst = 1'b0;
        wait_stb(n, hi, ol);
        chk("post_rst_period", n, 32);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
